// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared types and helpers for the bit-serial subtractor.
//               state_t   - control FSM encoding (IDLE, BUSY, DONE)
//               cnt_width - bit-counter width for a given operand width
// Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must be able to hold 0..w and be at least one bit wide,
    // so that a one-bit datapath still has a legal counter.
    function automatic int cnt_width(input int w);
        int c;
        c = $clog2(w + 1);
        return (c < 1) ? 1 : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_half_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : half_subtractor
// Description : One-bit half subtractor, x - y.
// Ports       : x      - minuend bit
//               y      - subtrahend bit
//               diff   - x ^ y
//               borrow - set when x = 0 and y = 1
// Revision    : 1.0 - initial release
// ============================================================================
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic diff,
    output logic borrow
);

    assign diff   = x ^ y;
    assign borrow = ~x & y;

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor, diff = (a - b) mod 2^W and
//               borrow = (a < b). One bit per clock, LSB first, with
//               valid/ready handshakes on both sides. Operations never overlap.
// Ports       : clk       - rising-edge clock
//               rst       - synchronous active-high reset
//               in_valid  - a/b are valid
//               in_ready  - block is idle and can accept a/b
//               a, b      - unsigned minuend / subtrahend
//               out_valid - diff/borrow are valid (held until out_ready)
//               out_ready - downstream accepts the result
//               diff      - (a - b) mod 2^DATA_WIDTH
//               borrow    - 1 iff a < b
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  borrow
);

    localparam int                 c_cnt_w = cnt_width(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_WIDTH - 1);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic                    r_bflop;
    logic [c_cnt_w-1:0]      r_cnt;

    logic                    w_d1;
    logic                    w_b1;
    logic                    w_dbit;
    logic                    w_b2;
    logic                    w_bout;
    logic                    w_busy;
    logic [DATA_WIDTH-1:0]   w_res_next;

    // Full-subtract bit slice built from two half subtractors.
    half_subtractor u_hs_xy (
        .x      (r_a[0]),
        .y      (r_b[0]),
        .diff   (w_d1),
        .borrow (w_b1)
    );

    half_subtractor u_hs_bin (
        .x      (w_d1),
        .y      (r_bflop),
        .diff   (w_dbit),
        .borrow (w_b2)
    );

    assign w_bout   = w_b1 | w_b2;
    assign w_busy   = (r_state == BUSY);
    assign in_ready = (r_state == IDLE);

    // The result shift register only needs DATA_WIDTH-1 bits: the final diff
    // bit is taken straight from the slice and concatenated on the last cycle,
    // so the full word lands in diff in the same edge that enters DONE.
    generate
        if (DATA_WIDTH == 1) begin : g_res_single
            assign w_res_next = w_dbit;
        end else begin : g_res_shift
            logic [DATA_WIDTH-2:0] r_res;

            assign w_res_next = {w_dbit, r_res};

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_res <= '0;
                end else if (w_busy) begin
                    r_res <= w_res_next[DATA_WIDTH-1:1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_bflop   <= 1'b0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_bflop <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_bflop <= w_bout;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        // Borrow out of the MSB is exactly the a < b flag.
                        diff      <= w_res_next;
                        borrow    <= w_bout;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor. Drives an 8-bit
//               and a 1-bit instance; expected results come from plain
//               arithmetic (a - b, a < b) on the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       borrow;

    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic [0:0] diff1;
    logic       borrow1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.DATA_WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    serial_subtractor #(.DATA_WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .diff      (diff1),
        .borrow    (borrow1)
    );

    // Reference model: {borrow, diff} for an 8-bit unsigned subtraction.
    function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] d;
        d = 8'(int'(x) - int'(y) + 256);
        return {(x < y), d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: in_ready=%0b required 1", in_ready);
        end
    endtask

    // Stimulus driver only: one operation on the 8-bit instance, out_ready=1.
    task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, output int lat);
        wait_idle();
        a         = xa;
        b         = xb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_valid1  = 1'b0;
        out_ready  = 1'b0;
        out_ready1 = 1'b0;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++;
        if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff: got %h required 00", diff); end
        checks++;
        if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b required 0", borrow); end
        checks++;
        if ({in_ready1, out_valid1} !== 2'b10) begin
            errors++;
            $display("FAIL reset_w1: in_ready1/out_valid1 got %b%b required 10", in_ready1, out_valid1);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat;
        do_op(8'h5A, 8'h21, lat);
        checks++;
        if (diff !== 8'h39) begin errors++; $display("FAIL basic_diff: got %h required 39", diff); end
        checks++;
        if (borrow !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b required 0", borrow); end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d required 8", lat); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b required 0", out_valid); end
    endtask

    task automatic test_corners();
        logic [7:0] pa [3];
        logic [7:0] pb [3];
        logic [7:0] ed [3];
        logic       eb [3];
        int         lat;
        pa = '{8'h00, 8'h80, 8'hFF};
        pb = '{8'h01, 8'h80, 8'h00};
        ed = '{8'hFF, 8'h00, 8'hFF};
        eb = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_op(pa[i], pb[i], lat);
            checks++;
            if (diff !== ed[i] || borrow !== eb[i]) begin
                errors++;
                $display("FAIL corner_%0d: got diff=%h borrow=%b required diff=%h borrow=%b",
                         i, diff, borrow, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        int lat;
        wait_idle();
        a         = 8'h10;
        b         = 8'h03;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        // Next operands offered while the result is stalled.
        a        = 8'h77;
        b        = 8'h11;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || diff !== 8'h0D || borrow !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid=%b diff=%h borrow=%b in_ready=%b required 1 0d 0 0",
                         i, out_valid, diff, borrow, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1 || diff !== 8'h66 || borrow !== 1'b0 || lat !== 8) begin
            errors++;
            $display("FAIL bp_next_op: got valid=%b diff=%h borrow=%b lat=%0d required 1 66 0 8",
                     out_valid, diff, borrow, lat);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int lat;
        wait_idle();
        a         = 8'h12;
        b         = 8'h34;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got in_ready=%b valid=%b diff=%h borrow=%b required 1 0 00 0",
                     in_ready, out_valid, diff, borrow);
        end
        seen = 1'b0;
        repeat (20) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_result: got %b required 0", seen); end
        do_op(8'h03, 8'h05, lat);
        checks++;
        if (diff !== 8'hFE || borrow !== 1'b1) begin
            errors++;
            $display("FAIL midreset_new_op: got diff=%h borrow=%b required fe 1", diff, borrow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa [3];
        logic [7:0] pb [3];
        logic [8:0] q [$];
        logic [8:0] exp;
        int idx, cyc, got, last;
        bit acc, ret;
        for (int i = 0; i < 3; i++) begin
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
        end
        wait_idle();
        out_ready = 1'b1;
        idx = 0; cyc = 0; got = 0; last = -1;
        a = pa[0];
        b = pb[0];
        in_valid = 1'b1;
        while (got < 3 && cyc < 100) begin
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            if (ret) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got diff=%h with no operation pending", diff);
                end else begin
                    exp = q.pop_front();
                    if ({borrow, diff} !== exp) begin
                        errors++;
                        $display("FAIL b2b_result_%0d: got %h required %h", got, {borrow, diff}, exp);
                    end
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 10) begin
                        errors++;
                        $display("FAIL b2b_spacing_%0d: got %0d required 10", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            step();
            cyc++;
            if (acc) begin
                q.push_back(ref_sub(pa[idx], pb[idx]));
                idx++;
                if (idx < 3) begin
                    a = pa[idx];
                    b = pb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 3) begin errors++; $display("FAIL b2b_count: got %0d required 3", got); end
    endtask

    task automatic test_random();
        logic [8:0] q [$];
        logic [8:0] exp;
        logic [8:0] held;
        int  sent, got, cyc;
        bit  acc, ret, stalled;
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
        wait_idle();
        a = 8'($urandom);
        b = 8'($urandom);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (got < 1000 && cyc < 40000) begin
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {borrow, diff} !== held) begin
                    errors++;
                    $display("FAIL rnd_hold: got valid=%b result=%h required 1 %h",
                             out_valid, {borrow, diff}, held);
                end
            end
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            stalled = out_valid && !out_ready;
            held    = {borrow, diff};
            if (ret) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_unexpected: got diff=%h with no operation pending", diff);
                end else begin
                    exp = q.pop_front();
                    if ({borrow, diff} !== exp) begin
                        errors++;
                        $display("FAIL rnd_result_%0d: got %h required %h", got, {borrow, diff}, exp);
                    end
                end
                got++;
            end
            step();
            cyc++;
            if (acc) begin
                q.push_back(ref_sub(a, b));
                sent++;
                a = 8'($urandom);
                b = 8'($urandom);
                in_valid = 1'b0;
            end
            // Once offered, operands stay valid until taken.
            if (!in_valid && sent < 1000) in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 1000) begin errors++; $display("FAIL rnd_count: got %0d required 1000", got); end
    endtask

    task automatic test_width1();
        logic ed [4];
        logic eb [4];
        int   n, lat;
        // Index is {a, b}: 0-0, 0-1, 1-0, 1-1.
        ed = '{1'b0, 1'b1, 1'b1, 1'b0};
        eb = '{1'b0, 1'b1, 1'b0, 1'b0};
        out_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!in_ready1 && n < 10) begin
                step();
                n++;
            end
            a1 = 1'((i >> 1) & 1);
            b1 = 1'(i & 1);
            in_valid1 = 1'b1;
            step();
            in_valid1 = 1'b0;
            lat = 0;
            while (!out_valid1 && lat < 10) begin
                step();
                lat++;
            end
            checks++;
            if (out_valid1 !== 1'b1 || diff1[0] !== ed[i] || borrow1 !== eb[i] || lat !== 1) begin
                errors++;
                $display("FAIL w1_case_%0d: got valid=%b diff=%b borrow=%b lat=%0d required 1 %b %b 1",
                         i, out_valid1, diff1[0], borrow1, lat, ed[i], eb[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor. It computes diff = a - b (mod 2^DATA_WIDTH) and a borrow-out flag, one bit per clock, LSB first. It is the inverse-direction companion to the combinational adder primitives in the arithmetic library and is built from a half_subtractor cell. It is intended for area-constrained datapaths and uses valid/ready handshakes on both input and output.

Parameters:
DATA_WIDTH, 8, operand and result width in bits; legal range is 1 or more.

Ports:
clk  input  1  rising-edge clock; the only clock in the block.
rst  input  1  reset; synchronous, active-high.
in_valid  input  1  operands a and b are valid.
in_ready  output  1  block can accept operands.
a  input  DATA_WIDTH  minuend, unsigned.
b  input  DATA_WIDTH  subtrahend, unsigned.
out_valid  output  1  diff and borrow are valid.
out_ready  input  1  downstream accepts the result.
diff  output  DATA_WIDTH  (a - b) mod 2^DATA_WIDTH.
borrow  output  1  1 iff a < b, unsigned.

Behaviour:
- Reset: on rst=1 at a clk edge, the block goes to IDLE.
  - Reset values: in_ready=1, out_valid=0, diff=0, borrow=0, bit counter=0, operand shift registers=0, borrow flop=0.
  - Reset takes priority over every other event, including mid-operation: the operation in flight is aborted and no result is produced.
- FSM states: IDLE, BUSY, DONE (enum defined in the package).
  - IDLE: in_ready=1. When in_valid=1, capture a and b into shift registers, clear the borrow flop and counter, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle:
    - Full-subtract bit0 of the a register, bit0 of the b register and the borrow flop.
    - Shift the diff bit into the MSB of the result shift register.
    - Shift both operand registers right by one.
    - Update the borrow flop and increment the counter.
    - After the DATA_WIDTH-th bit, go to DONE.
  - DONE: out_valid=1. diff and borrow are held stable until out_ready=1. On the out_ready=1 edge, go to IDLE.
- Full-subtract per bit:
  - Stage 1: half_subtractor(x, y) gives d1 and b1.
  - Stage 2: half_subtractor(d1, bin) gives the diff bit and b2.
  - bout = b1 | b2.
- Latency: operands accepted at edge N, so out_valid is high starting in the cycle after edge N+DATA_WIDTH.
  - Throughput: one result per DATA_WIDTH+2 cycles with out_ready held at 1.
  - The block does not overlap operations.
- Handshake rules:
  - in_valid while in_ready=0 is ignored; the upstream must hold its data.
  - in_ready is combinational from state only and does not depend on in_valid.
  - out_valid, diff and borrow are registered. diff and borrow do not change while out_valid=1 and out_ready=0.
- Back-to-back: in DONE with out_ready=1 the block returns to IDLE. The next operands are accepted in IDLE, one cycle later; there is no IDLE-bypass.
- DATA_WIDTH=1: the counter is at least 1 bit wide. BUSY lasts exactly 1 cycle.
- Outputs while not in DONE: diff and borrow keep their last result; they are meaningful only while out_valid=1.

Decomposition:
- Package serial_subtractor_pkg:
  - typedef enum logic [1:0] state_t {IDLE, BUSY, DONE}.
  - Function cnt_width(int w) returning max(1, $clog2(w+1)).
- Sub-module half_subtractor, instantiated twice in the bit slice:
  - Ports x, y, diff, borrow.
  - diff = x ^ y; borrow = ~x & y.

Test Plan:
- DATA_WIDTH=8, a=0x5A, b=0x21, out_ready=1: diff=0x39, borrow=0. out_valid rises 8 cycles after acceptance and stays high for 1 cycle.
- a=0x00, b=0x01: diff=0xFF, borrow=1. Also a=0x80, b=0x80: diff=0x00, borrow=0. Also a=0xFF, b=0x00: diff=0xFF, borrow=0.
- Backpressure: a=0x10, b=0x03 with out_ready=0 for 5 cycles. out_valid stays 1 with diff=0x0D and borrow=0 held stable; in_ready stays 0 while in_valid=1 is driven with a=0x77. On the out_ready edge the block returns to IDLE, then accepts 0x77.
- Reset mid-operation: rst=1 during BUSY at bit 4. The next cycle shows in_ready=1, out_valid=0, diff=0, borrow=0, and no result is ever emitted. A new op a=0x03, b=0x05 completes with diff=0xFE, borrow=1.
- Back-to-back with in_valid held at 1 and 3 operand pairs: results arrive in order, spaced 10 cycles apart. Checked against a random scoreboard of 1000 pairs plus DATA_WIDTH=1 exhaustive (0-0, 0-1, 1-0, 1-1 giving diff/borrow 0/0, 1/1, 1/0, 0/0).
